// File: rtl/regfile_scoreboard.sv
// Eight-entry 16-bit register file with a per-register pending-write
// scoreboard. Issue is stalled on RAW (either source) or WAW hazards against
// outstanding writes. A writeback releases its register in the same cycle
// through the bypass path. A writeback to a register with no outstanding
// write raises a one-cycle Err pulse but is still stored.
module regfile_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ReadReg1,
  input  logic [2:0]  ReadReg2,
  input  logic        Read1En,
  input  logic        Read2En,
  input  logic        IssueValid,
  input  logic        IssueWrEn,
  input  logic [2:0]  IssueDst,
  input  logic        WriteEn,
  input  logic [2:0]  WriteReg,
  input  logic [15:0] WriteData,
  output logic [15:0] Read1Data,
  output logic [15:0] Read2Data,
  output logic        Stall,
  output logic        Err
);

  localparam int NREG = 8;

  // Architectural state
  logic [15:0] r_regs    [NREG];
  logic        r_pending [NREG];
  logic        r_err;

  // Combinational decode
  logic            w_bypass1;
  logic            w_bypass2;
  logic            w_wb_dst;
  logic            w_haz1;
  logic            w_haz2;
  logic            w_waw;
  logic            w_stall;
  logic            w_fire;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // A writeback that targets a read port's register is forwarded this cycle.
  assign w_bypass1 = WriteEn & (WriteReg == ReadReg1);
  assign w_bypass2 = WriteEn & (WriteReg == ReadReg2);
  assign w_wb_dst  = WriteEn & (WriteReg == IssueDst);

  assign Read1Data = w_bypass1 ? WriteData : r_regs[ReadReg1];
  assign Read2Data = w_bypass2 ? WriteData : r_regs[ReadReg2];

  // A pending register stops being a hazard in the cycle its writeback lands.
  assign w_haz1 = Read1En   & r_pending[ReadReg1] & ~w_bypass1;
  assign w_haz2 = Read2En   & r_pending[ReadReg2] & ~w_bypass2;
  assign w_waw  = IssueWrEn & r_pending[IssueDst] & ~w_wb_dst;

  // Stall is forced low during reset so upstream never sees a stale hazard.
  assign w_stall = ~rst & IssueValid & (w_haz1 | w_haz2 | w_waw);
  assign w_fire  = IssueValid & ~w_stall;
  assign Stall   = w_stall;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      assign w_set[gi] = w_fire & IssueWrEn & (IssueDst == 3'(gi));
      assign w_clr[gi] = WriteEn & (WriteReg == 3'(gi));

      // Register storage: writeback updates the entry, reset clears it.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_regs[gi] <= '0;
        end else if (w_clr[gi]) begin
          r_regs[gi] <= WriteData;
        end
      end

      // Pending bit: a new issue outranks a same-cycle writeback so the
      // younger write stays tracked.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pending[gi] <= 1'b0;
        end else if (w_set[gi]) begin
          r_pending[gi] <= 1'b1;
        end else if (w_clr[gi]) begin
          r_pending[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Protocol check: flag a writeback that no issued instruction was waiting on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= WriteEn & ~r_pending[WriteReg];
    end
  end

  assign Err = r_err;

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 The module SHALL have the port: clk  input  1  rising-edge clock for all state.
REQ-003 The module SHALL have the port: rst  input  1  synchronous active-high reset.
REQ-004 The module SHALL have the port: ReadReg1  input  3  source register index, port 1.
REQ-005 The module SHALL have the port: ReadReg2  input  3  source register index, port 2.
REQ-006 The module SHALL have the port: Read1En  input  1  port 1 operand is consumed by the issuing instruction.
REQ-007 The module SHALL have the port: Read2En  input  1  port 2 operand is consumed by the issuing instruction.
REQ-008 The module SHALL have the port: IssueValid  input  1  an instruction is presented for issue this cycle.
REQ-009 The module SHALL have the port: IssueWrEn  input  1  the issuing instruction will write a register.
REQ-010 The module SHALL have the port: IssueDst  input  3  destination index of the issuing instruction.
REQ-011 The module SHALL have the port: WriteEn  input  1  writeback write strobe.
REQ-012 The module SHALL have the port: WriteReg  input  3  writeback destination index.
REQ-013 The module SHALL have the port: WriteData  input  16  writeback value.
REQ-014 The module SHALL have the port: Read1Data  output  16  operand 1.
REQ-015 The module SHALL have the port: Read2Data  output  16  operand 2.
REQ-016 The module SHALL have the port: Stall  output  1  issue blocked this cycle.
REQ-017 The module SHALL have the port: Err  output  1  registered protocol-violation pulse.

Function
REQ-018 Storage SHALL be R0-R7, 16 bits each, all writable (no hardwired zero).
REQ-019 On a rising edge with WriteEn=1 and rst=0, R[WriteReg] SHALL take WriteData.
REQ-020 ReadNData SHALL be combinational: WriteData when WriteEn=1 and WriteReg==ReadRegN (same-cycle bypass), else R[ReadRegN].
REQ-021 Scoreboard: 8 pending bits, one per register; pending[i]=1 means an issued write to Ri has not yet reached writeback.
REQ-022 Issue fires when IssueValid=1 and Stall=0.
REQ-023 Issue with IssueWrEn=1 SHALL set pending[IssueDst] at the next edge.
REQ-024 WriteEn=1 SHALL clear pending[WriteReg] at the next edge.
REQ-025 When set and clear target the same register in one cycle, set SHALL win (pending stays 1).
REQ-026 Source N is hazarded when ReadNEn=1, pending[ReadRegN]=1, and NOT (WriteEn=1 and WriteReg==ReadRegN).
REQ-027 WAW is hazarded when IssueWrEn=1, pending[IssueDst]=1, and NOT (WriteEn=1 and WriteReg==IssueDst).
REQ-028 Stall SHALL be combinational: IssueValid AND (hazard1 OR hazard2 OR WAW); Stall=0 whenever IssueValid=0.
REQ-029 A stalled instruction SHALL NOT modify the scoreboard; writeback during stall SHALL proceed normally.
REQ-030 Err SHALL pulse high for exactly one cycle following any edge where WriteEn=1 and pending[WriteReg]=0.
REQ-031 Err SHALL NOT block the write; data is still stored.
REQ-032 Latency: write visible via bypass in the same cycle, via array from the next cycle; stall release occurs in the writeback cycle itself.

Reset
REQ-033 On a rising edge with rst=1: all R0-R7 SHALL become 0x0000, all pending bits 0, Err 0; WriteEn and issue SHALL be ignored in that cycle.
REQ-034 While rst=1, Stall SHALL be driven 0.
REQ-035 Reset mid-operation SHALL discard outstanding pending writes; a later WriteEn to such a register SHALL raise Err.

Verification
REQ-036 Reset, then read all eight registers -> 0x0000 on both ports; Stall=0; Err=0.
REQ-037 Issue IssueDst=3, IssueWrEn=1; next cycle issue ReadReg1=3, Read1En=1 with WriteEn=0 -> Stall=1; same with WriteEn=1, WriteReg=3, WriteData=0xBEEF -> Stall=0, Read1Data=0xBEEF.
REQ-038 Issue and writeback of R5 in the same cycle (pending[5]=1 before) -> pending[5] remains 1; next issue reading R5 with Read1En=1 -> Stall=1.
REQ-039 Issue IssueDst=2 while pending[2]=1, no writeback -> Stall=1, scoreboard unchanged; with WriteEn=1, WriteReg=2 -> Stall=0.
REQ-040 WriteEn=1, WriteReg=6, WriteData=0x1234 with pending[6]=0 -> Err=1 for one cycle; R6 reads 0x1234.
REQ-041 Pending[1]=1, assert rst for one cycle, then WriteEn=1, WriteReg=1 -> Err=1 next cycle; Read1Data for R1=WriteData.
